// File: rtl/btn_charge.sv
// Button conditioner and charge meter for the jump FSM: synchronises and debounces btn, measures
// hold time as a charge level and offers it as jump_power over valid/ready on release.
// Optional build macro CHARGE_PINGPONG_EN makes charge ramp up and down instead of saturating.
module btn_charge #(
  parameter int DEB_CYCLES = 50000,
  parameter int CHARGE_W   = 8,
  parameter int CHARGE_MAX = 255,
  parameter int CHARGE_DIV = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn,
  input  logic                jump_ready,
  output logic                jump_valid,
  output logic [CHARGE_W-1:0] jump_power,
  output logic [CHARGE_W-1:0] charge,
  output logic                charging
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CHARGE_DIV - 1);
  localparam logic [CHARGE_W-1:0] C_MAX    = CHARGE_W'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] C_ONE    = CHARGE_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    OFFER  = 2'd2
  } state_e;

  // Input conditioning state
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic             armed_q, armed_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_dly_q, btn_db_dly_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Charge FSM state
  state_e              state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic                jump_valid_q, jump_valid_d;
  logic [CHARGE_W-1:0] jump_power_q, jump_power_d;
  logic                charging_q, charging_d;
`ifdef CHARGE_PINGPONG_EN
  logic                dir_down_q, dir_down_d;
  logic                dir_step;
`endif

  logic                rise;
  logic                fall;
  logic [PRE_W-1:0]    presc_step;
  logic [CHARGE_W-1:0] charge_step;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d         = btn;
    s2_d         = s1_q;
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    btn_db_d     = btn_db_q;
    deb_cnt_d    = '0;
    btn_db_dly_d = btn_db_q;
    if (s2_q != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    // A button held through reset must be seen released before any press counts.
    armed_d = armed_q | (sync_vld_q[1] & ~s2_q & ~btn_db_q);
  end

  assign rise = btn_db_q & ~btn_db_dly_q;
  assign fall = ~btn_db_q & btn_db_dly_q;

  // Value charge would take this cycle if still in CHARGE; a release on a wrap cycle sees it.
  always_comb begin
    presc_step  = presc_q + PRE_W'(1);
    charge_step = charge_q;
`ifdef CHARGE_PINGPONG_EN
    dir_step    = dir_down_q;
`endif
    if (presc_q == PRE_LAST) begin
      presc_step = '0;
`ifdef CHARGE_PINGPONG_EN
      if (!dir_down_q) begin
        if (charge_q >= C_MAX) begin
          dir_step    = 1'b1;
          charge_step = (CHARGE_MAX > 1) ? C_MAX - C_ONE : C_MAX;
        end else begin
          charge_step = charge_q + C_ONE;
        end
      end else begin
        if (charge_q <= C_ONE) begin
          dir_step    = 1'b0;
          charge_step = (CHARGE_MAX > 1) ? CHARGE_W'(2) : C_ONE;
        end else begin
          charge_step = charge_q - C_ONE;
        end
      end
`else
      if (charge_q < C_MAX) begin
        charge_step = charge_q + C_ONE;
      end
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    charge_d     = charge_q;
    jump_valid_d = jump_valid_q;
    jump_power_d = jump_power_q;
`ifdef CHARGE_PINGPONG_EN
    dir_down_d   = dir_down_q;
`endif
    unique case (state_q)
      IDLE: begin
        charge_d = '0;
        if (rise && jump_ready && armed_q) begin
          state_d  = CHARGE;
          presc_d  = '0;
`ifdef CHARGE_PINGPONG_EN
          dir_down_d = 1'b0;
`endif
        end
      end
      CHARGE: begin
        presc_d  = presc_step;
        charge_d = charge_step;
`ifdef CHARGE_PINGPONG_EN
        dir_down_d = dir_step;
`endif
        if (fall) begin
          charge_d = '0;
          if (charge_step != '0) begin
            state_d      = OFFER;
            jump_power_d = charge_step;
            jump_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OFFER: begin
        jump_valid_d = 1'b1;
        if (jump_valid_q && jump_ready) begin
          state_d      = IDLE;
          jump_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        charge_d     = '0;
        jump_valid_d = 1'b0;
      end
    endcase
    charging_d = (state_d == CHARGE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      sync_vld_q   <= '0;
      armed_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      deb_cnt_q    <= '0;
      state_q      <= IDLE;
      presc_q      <= '0;
      charge_q     <= '0;
      jump_valid_q <= 1'b0;
      jump_power_q <= '0;
      charging_q   <= 1'b0;
`ifdef CHARGE_PINGPONG_EN
      dir_down_q   <= 1'b0;
`endif
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      sync_vld_q   <= sync_vld_d;
      armed_q      <= armed_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      presc_q      <= presc_d;
      charge_q     <= charge_d;
      jump_valid_q <= jump_valid_d;
      jump_power_q <= jump_power_d;
      charging_q   <= charging_d;
`ifdef CHARGE_PINGPONG_EN
      dir_down_q   <= dir_down_d;
`endif
    end
  end

  assign jump_valid = jump_valid_q;
  assign jump_power = jump_power_q;
  assign charge     = charge_q;
  assign charging   = charging_q;

endmodule

// File: tb/tb_btn_charge.sv
// Directed bench for btn_charge with DEB_CYCLES=4, CHARGE_DIV=2, CHARGE_MAX=7; jump_power
// expectations go through a scoreboard queue from release to offer.
module tb_btn_charge;

  localparam int DEB = 4;
  localparam int DIV = 2;
  localparam int MAX = 7;
  localparam int W   = 8;
  // btn edge to debounced fall is 2 sync + DEB debounce cycles, plus one cycle to offer.
  localparam int REL_LAT = 2 + DEB + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         btn;
  logic         jump_ready;
  logic         jump_valid;
  logic [W-1:0] jump_power;
  logic [W-1:0] charge;
  logic         charging;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];

  btn_charge #(
    .DEB_CYCLES(DEB),
    .CHARGE_W  (W),
    .CHARGE_MAX(MAX),
    .CHARGE_DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .jump_ready(jump_ready),
    .jump_valid(jump_valid),
    .jump_power(jump_power),
    .charge    (charge),
    .charging  (charging)
  );

  always #5 clk = ~clk;

  // Charge level after k cycles spent in CHARGE.
  function automatic int exp_charge(input int k);
    int c;
    int steps;
    bit down;
    c     = 0;
    down  = 1'b0;
    steps = k / DIV;
    for (int s = 0; s < steps; s++) begin
`ifdef CHARGE_PINGPONG_EN
      if (!down) begin
        if (c >= MAX) begin down = 1'b1; c = MAX - 1; end
        else c = c + 1;
      end else begin
        if (c <= 1) begin down = 1'b0; c = 2; end
        else c = c - 1;
      end
`else
      if (c < MAX) c = c + 1;
`endif
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0d expected <none queued>", tag, obs);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_charging(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (charging === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Press, stay hold cycles in CHARGE checking the live level, release and collect the offer.
  task automatic press_release(input string tag, input int hold, input logic ready_rel);
    bit ok;
    int lat;
    btn = 1'b1;
    wait_charging(ok);
    check({tag, " enter"}, 32'(ok), 1);
    if (!ok) begin
      btn = 1'b0;
      idle(20);
      return;
    end
    for (int j = 0; j <= hold; j++) begin
      if (j > 0) @(negedge clk);
      check({tag, " live"}, 32'(charge), exp_charge(j));
    end
    jump_ready = ready_rel;
    btn        = 1'b0;
    sb_q.push_back(exp_charge(hold + REL_LAT));
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (jump_valid === 1'b1) break;
    end
    check({tag, " latency"}, lat, REL_LAT);
    sb_pop_check({tag, " power"}, 32'(jump_power));
    check({tag, " charge0"}, 32'(charge), 0);
    check({tag, " charging0"}, 32'(charging), 0);
    if (ready_rel) begin
      @(negedge clk);
      check({tag, " valid drop"}, 32'(jump_valid), 0);
      check({tag, " power keep"}, 32'(jump_power), exp_charge(hold + REL_LAT));
    end
  endtask

  initial begin
    int bad;
    rst_n      = 1'b0;
    btn        = 1'b0;
    jump_ready = 1'b1;

    // Reset state
    idle(2);
    check("rst valid", 32'(jump_valid), 0);
    check("rst power", 32'(jump_power), 0);
    check("rst charge", 32'(charge), 0);
    check("rst charging", 32'(charging), 0);
    rst_n = 1'b1;
    idle(10);

    // Normal press: 10 cycles in CHARGE at release -> 5
    press_release("normal", 3, 1'b1);
    idle(5);

    // Ceiling (saturating) or ping-pong turnaround
`ifdef CHARGE_PINGPONG_EN
    press_release("pingpong", 9, 1'b1);
`else
    press_release("saturate", 33, 1'b1);
`endif
    idle(5);

    // Handshake: offer held while FSM is busy, extra press ignored
    press_release("hs", 3, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) btn = 1'b1;
      if (i == 10) btn = 1'b0;
      if (jump_valid !== 1'b1 || jump_power !== exp_charge(3 + REL_LAT) || charging !== 1'b0) bad++;
    end
    check("hs hold stable", bad, 0);
    jump_ready = 1'b1;
    @(negedge clk);
    check("hs accept valid", 32'(jump_valid), 0);
    check("hs accept power", 32'(jump_power), exp_charge(3 + REL_LAT));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (jump_valid !== 1'b0 || charging !== 1'b0) bad++;
    end
    check("hs accepted once", bad, 0);

    // Blocked press: rise with ready low, then ready rises while still held
    jump_ready = 1'b0;
    btn        = 1'b1;
    bad        = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (charging !== 1'b0) bad++;
    end
    check("blocked no charge", bad, 0);
    jump_ready = 1'b1;
    bad        = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (charging !== 1'b0) bad++;
    end
    check("blocked ready late", bad, 0);
    btn = 1'b0;
    idle(12);

    // Bounce: pulses shorter than the debounce window never start a charge
    bad = 0;
    for (int p = 0; p < 6; p++) begin
      btn = 1'b1;
      repeat ((p % 3) + 1) begin
        @(negedge clk);
        if (charging !== 1'b0) bad++;
      end
      btn = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (charging !== 1'b0) bad++;
      end
    end
    idle(8);
    if (charging !== 1'b0) bad++;
    check("bounce filtered", bad, 0);

    // Reset mid-CHARGE with button held
    btn = 1'b1;
    begin
      bit ok;
      wait_charging(ok);
      check("rstmid enter", 32'(ok), 1);
    end
    idle(6);
    check("rstmid charge", 32'(charge), exp_charge(6));
    #1 rst_n = 1'b0;
    #1;
    check("rstmid valid", 32'(jump_valid), 0);
    check("rstmid power", 32'(jump_power), 0);
    check("rstmid charge0", 32'(charge), 0);
    check("rstmid charging", 32'(charging), 0);
    idle(2);
    rst_n = 1'b1;
    bad   = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (charging !== 1'b0 || jump_valid !== 1'b0) bad++;
    end
    check("held at reset ignored", bad, 0);
    btn = 1'b0;
    idle(15);
    press_release("post rst", 3, 1'b1);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard drain: observed %0d left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
